n_bit_1x4_demux_router: RTL and testbench

- Registered 1-to-4 steering block; routes one N-bit word from a single producer to one of four consumer channels, selected per transfer by a 2-bit channel index.
- Producer side and each consumer side use valid/ready handshakes.
- Used in the datapath wherever one result must be delivered to one of four destinations, e.g. writeback fan-out or memory-mapped store dispatch.
- One-entry output buffer; full throughput when the selected consumer is ready every cycle.
- Per-channel transfer counters for debug and performance monitoring.

---
 rtl/n_bit_1x4_demux_router.sv | 124 ++++++++++++
 tb/tb_n_bit_1x4_demux_router.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/n_bit_1x4_demux_router.sv
// n_bit_1x4_demux_router: registered 1-to-4 steering block with valid/ready
// handshakes, a one-entry output buffer and per-channel transfer counters.
module n_bit_1x4_demux_router #(
   parameter int N  = 32,
   parameter int CW = 8
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [N-1:0]    in_data,
   input  logic [1:0]      in_sel,
   output logic [3:0]      out_valid,
   input  logic [3:0]      out_ready,
   output logic [4*N-1:0]  out_data,
   output logic            busy,
   output logic [4*CW-1:0] cnt_flat
);

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } state_t;

   state_t        state;
   state_t        state_nxt;
   logic [N-1:0]  data_q;
   logic [N-1:0]  data_nxt;
   logic [1:0]    sel_q;
   logic [1:0]    sel_nxt;
   logic [CW-1:0] cnt_q [4];
   logic          accept;
   logic          drain;

   // Handshake decode: only the selected consumer's ready can drain the buffer,
   // and a drain frees the slot so the producer can refill in the same cycle.
   always_comb begin
      drain    = 1'b0;
      in_ready = 1'b1;
      if (state == BUSY) begin
         drain    = out_ready[sel_q];
         in_ready = out_ready[sel_q];
      end
      accept = in_valid && in_ready;
   end

   // Next-state logic: the buffer loads on every accept and empties on a drain
   // that is not matched by a simultaneous refill.
   always_comb begin
      state_nxt = state;
      data_nxt  = data_q;
      sel_nxt   = sel_q;
      case (state)
         IDLE: begin
            if (accept) begin
               state_nxt = BUSY;
               data_nxt  = in_data;
               sel_nxt   = in_sel;
            end
         end
         BUSY: begin
            if (drain) begin
               if (accept) begin
                  state_nxt = BUSY;
                  data_nxt  = in_data;
                  sel_nxt   = in_sel;
               end else begin
                  state_nxt = IDLE;
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // State and buffer registers; an asynchronous reset discards any held word.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state  <= IDLE;
         data_q <= '0;
         sel_q  <= '0;
      end else begin
         state  <= state_nxt;
         data_q <= data_nxt;
         sel_q  <= sel_nxt;
      end
   end

   // Transfer counters: the channel being drained (old index) counts up by one,
   // wrapping naturally at 2^CW.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int k = 0; k < 4; k++) begin
            cnt_q[k] <= '0;
         end
      end else begin
         for (int k = 0; k < 4; k++) begin
            if (drain && (sel_q == 2'(k))) begin
               cnt_q[k] <= cnt_q[k] + 1'b1;
            end
         end
      end
   end

   // Output decode purely from registered state, so nothing on in_* reaches out_*.
   always_comb begin
      out_valid = '0;
      out_data  = '0;
      busy      = (state == BUSY);
      if (state == BUSY) begin
         out_valid[sel_q]       = 1'b1;
         out_data[sel_q*N +: N] = data_q;
      end
   end

   // Flatten the counter array onto the debug bus.
   always_comb begin
      cnt_flat = '0;
      for (int k = 0; k < 4; k++) begin
         cnt_flat[k*CW +: CW] = cnt_q[k];
      end
   end

endmodule

// File: tb/tb_n_bit_1x4_demux_router.sv
// tb_n_bit_1x4_demux_router: directed self-checking bench for the 1-to-4 router.
module tb_n_bit_1x4_demux_router;

   localparam int N  = 32;
   localparam int CW = 8;

   logic            clk;
   logic            rst;
   logic            in_valid;
   logic            in_ready;
   logic [N-1:0]    in_data;
   logic [1:0]      in_sel;
   logic [3:0]      out_valid;
   logic [3:0]      out_ready;
   logic [4*N-1:0]  out_data;
   logic            busy;
   logic [4*CW-1:0] cnt_flat;

   int checks = 0;
   int errors = 0;

   n_bit_1x4_demux_router #(.N(N), .CW(CW)) dut (
      .clk      (clk),
      .rst      (rst),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .in_data  (in_data),
      .in_sel   (in_sel),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_data (out_data),
      .busy     (busy),
      .cnt_flat (cnt_flat)
   );

   // Free-running clock, rising edges at 5, 15, 25 ...
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Compare one observed value with its hand-computed expectation.
   task automatic checkOutput(input string tag, input logic [127:0] observed,
                              input logic [127:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         errors++;
         $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
      end
   endtask

   // Drive the producer/consumer inputs for the coming edge.
   task automatic applyStimulus(input logic v, input logic [N-1:0] d,
                                input logic [1:0] s, input logic [3:0] r);
      in_valid  = v;
      in_data   = d;
      in_sel    = s;
      out_ready = r;
   endtask

   // Advance through one rising edge and return at the following falling edge.
   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   function automatic logic [CW-1:0] cnt(input int k);
      return cnt_flat[k*CW +: CW];
   endfunction

   initial begin
      rst = 1'b0;
      applyStimulus(1'b0, '0, 2'b00, 4'b0000);
      step();
      step();
      rst = 1'b1;

      // Reset state
      checkOutput("rst_out_valid", 128'(out_valid), 128'h0);
      checkOutput("rst_out_data", 128'(out_data), 128'h0);
      checkOutput("rst_busy", 128'(busy), 128'h0);
      checkOutput("rst_cnt", 128'(cnt_flat), 128'h0);
      checkOutput("rst_in_ready", 128'(in_ready), 128'h1);

      // Single route to ch2
      applyStimulus(1'b1, 32'hDEADBEEF, 2'b10, 4'b1111);
      step();
      applyStimulus(1'b0, '0, 2'b00, 4'b1111);
      checkOutput("single_valid", 128'(out_valid), 128'h4);
      checkOutput("single_data", 128'(out_data), 128'h0000_0000_DEADBEEF_0000_0000_0000_0000);
      checkOutput("single_busy", 128'(busy), 128'h1);
      step();
      checkOutput("single_cnt2", 128'(cnt(2)), 128'h1);
      checkOutput("single_idle", 128'(busy), 128'h0);

      // Backpressure on ch1 with a competing request for ch3
      applyStimulus(1'b1, 32'h12345678, 2'b01, 4'b0000);
      step();
      applyStimulus(1'b1, 32'hAAAA5555, 2'b11, 4'b0000);
      for (int i = 0; i < 5; i++) begin
         checkOutput("bp_in_ready", 128'(in_ready), 128'h0);
         checkOutput("bp_valid", 128'(out_valid), 128'h2);
         checkOutput("bp_data", 128'(out_data), 128'h0000_0000_0000_0000_12345678_0000_0000);
         step();
      end
      applyStimulus(1'b0, '0, 2'b00, 4'b0010);
      step();
      checkOutput("bp_cnt1", 128'(cnt(1)), 128'h1);
      checkOutput("bp_cnt3", 128'(cnt(3)), 128'h0);
      checkOutput("bp_idle", 128'(busy), 128'h0);

      // Back-to-back stream, one word per channel
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1'b1, N'(i + 1), 2'(i), 4'b1111);
         step();
         checkOutput("b2b_busy", 128'(busy), 128'h1);
         checkOutput("b2b_valid", 128'(out_valid), 128'(4'b0001 << i));
         checkOutput("b2b_data", 128'(out_data), 128'(i + 1) << (32 * i));
      end
      applyStimulus(1'b0, '0, 2'b00, 4'b1111);
      step();
      checkOutput("b2b_idle", 128'(busy), 128'h0);
      checkOutput("b2b_cnt", 128'(cnt_flat), 128'h01_02_02_01);

      // Ready on the wrong channels must not drain ch3
      applyStimulus(1'b1, 32'hCAFEF00D, 2'b11, 4'b0111);
      step();
      applyStimulus(1'b0, '0, 2'b00, 4'b0111);
      for (int i = 0; i < 3; i++) begin
         checkOutput("wrong_valid", 128'(out_valid), 128'h8);
         checkOutput("wrong_cnt", 128'(cnt_flat), 128'h01_02_02_01);
         step();
      end
      applyStimulus(1'b0, '0, 2'b00, 4'b1000);
      step();
      checkOutput("wrong_cnt3", 128'(cnt(3)), 128'h2);
      checkOutput("wrong_idle", 128'(busy), 128'h0);

      // Asynchronous reset while a word is held
      applyStimulus(1'b1, 32'h00000055, 2'b00, 4'b0000);
      step();
      applyStimulus(1'b0, '0, 2'b00, 4'b0000);
      checkOutput("arst_pre_busy", 128'(busy), 128'h1);
      #2 rst = 1'b0;
      #1;
      checkOutput("arst_valid", 128'(out_valid), 128'h0);
      checkOutput("arst_busy", 128'(busy), 128'h0);
      checkOutput("arst_cnt", 128'(cnt_flat), 128'h0);
      @(negedge clk);
      rst = 1'b1;
      checkOutput("arst_in_ready", 128'(in_ready), 128'h1);

      // Counter wrap on ch0: 256 words streamed back to back
      for (int i = 0; i < 255; i++) begin
         applyStimulus(1'b1, N'(i), 2'b00, 4'b1111);
         step();
      end
      applyStimulus(1'b1, N'(255), 2'b00, 4'b1111);
      step();
      checkOutput("wrap_cnt0_255", 128'(cnt(0)), 128'hFF);
      checkOutput("wrap_busy", 128'(busy), 128'h1);
      applyStimulus(1'b0, '0, 2'b00, 4'b1111);
      step();
      checkOutput("wrap_cnt0_256", 128'(cnt(0)), 128'h00);
      checkOutput("wrap_others", 128'(cnt_flat[4*CW-1:CW]), 128'h0);
      checkOutput("wrap_idle", 128'(busy), 128'h0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
